// File: rtl/controle_exibicao.sv
`timescale 1ns/1ps
// Plays the current round's stored sequence on the LEDs: each entry lit for
// T_ACESO cycles, then blanked for T_APAGADO cycles, addresses 0..limite.
module controle_exibicao #(
  parameter int ADDR_W    = 4,
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TW    = $clog2(T_MAX) + 1;
  localparam logic [TW-1:0] FIM_ACESO   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    AVANCA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] limite_q, limite_d;
  logic [3:0]        leds_q, leds_d;
  logic [TW-1:0]     timer_q, timer_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      limite_q   <= '0;
      leds_q     <= '0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      leds_q     <= leds_d;
      timer_q    <= timer_d;
    end
  end

  // Handshake: iniciar is a start request honoured only in OCIOSO (ignored
  // while ocupado); pronto is a one-cycle completion strobe. abortar wins.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    leds_d     = leds_q;
    timer_d    = timer_q;
    if (abortar) begin
      estado_d = OCIOSO;
      leds_d   = '0;
      timer_d  = '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            estado_d   = CARREGA;
            limite_d   = limite;
            endereco_d = '0;
            leds_d     = '0;
            timer_d    = '0;
          end
        end
        CARREGA: begin
          estado_d = ACESO;
          leds_d   = dado_mem;
          timer_d  = '0;
        end
        ACESO: begin
          if (timer_q == FIM_ACESO) begin
            estado_d = APAGADO;
            leds_d   = '0;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        APAGADO: begin
          // Last-entry test happens before any increment, so endereco never wraps.
          if (timer_q == FIM_APAGADO) begin
            estado_d = (endereco_q == limite_q) ? FIM : AVANCA;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        AVANCA: begin
          estado_d   = CARREGA;
          endereco_d = endereco_q + ADDR_W'(1);
          timer_d    = '0;
        end
        FIM: begin
          estado_d = OCIOSO;
          timer_d  = '0;
        end
        default: begin
          estado_d = OCIOSO;
          leds_d   = '0;
          timer_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    endereco = endereco_q;
    leds     = leds_q;
    ocupado  = (estado_q != OCIOSO);
    pronto   = (estado_q == FIM);
    case (estado_q)
      OCIOSO, CARREGA, ACESO, APAGADO, AVANCA, FIM: db_estado = {1'b0, estado_q};
      default:                                       db_estado = 4'hF;
    endcase
  end

endmodule
